// File: rtl/diff_demo_pkg.sv
// Shared constants and types for the diff_demo load path.
// Provides the buffer geometry constants (CONF_*), the loader state enum,
// and a small width helper used when sizing column counters.
package diff_demo_pkg;

  localparam int unsigned CONF_PE_COL          = 4;
  localparam int unsigned CONF_FM_BUF_DEPTH    = 16;
  localparam int unsigned CONF_GUARD_BUF_DEPTH = 16;
  localparam int unsigned CONF_DATA_W          = 72;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_FM = 3'd1,
    LOAD_GD = 3'd2,
    REQ     = 3'd3,
    RUN     = 3'd4
  } load_state_e;

  // Counter width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/load_addr_cnt.sv
// Column/address walker for one load phase.
// Words are dealt round-robin across COLS columns; the address advances
// each time the last column has been written.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to column 0 / address 0 (phase entry)
//   inc        : one word accepted this cycle
//   words      : words per column for the current phase (non-zero when used)
//   col, addr  : position the next accepted word is written to
//   last       : next accepted word is the final one of the phase
module load_addr_cnt
  import diff_demo_pkg::*;
#(
  parameter  int unsigned COLS = CONF_PE_COL,
  parameter  int unsigned AW   = 4,
  localparam int unsigned CW   = clog2_min1(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW:0]   words,
  output logic [CW-1:0] col,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic col_wrap;

  assign col_wrap = (col == CW'(COLS - 1));
  assign last     = col_wrap && ({1'b0, addr} == (words - (AW+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      addr <= '0;
    end else if (inc) begin
      if (col_wrap) begin
        col  <= '0;
        addr <= addr + AW'(1);
      end else begin
        col  <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/core_load_ctrl.sv
// Load controller: streams fm words then guard words from a 72-bit input
// stream into COL_NUM column buffers, then hands one job to the core and
// waits for it to finish.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   start, fm_words_i, gd_words_i,
//   bit_mode_i, is_diff_i          : job request and its parameters (sampled in IDLE)
//   s_data, s_valid, s_ready       : input word stream
//   load_fm_wr_addr/din/wr_en      : fm buffer write ports, one per column
//   load_gd_wr_addr/din/wr_en      : guard buffer write ports, one per column
//   core_valid, core_ready         : job hand-off to the core
//   core_finish                    : core job complete pulse
//   core_bit_mode_o, core_is_diff_o: job modes held for the whole job
//   busy, done                     : controller status
module core_load_ctrl
  import diff_demo_pkg::*;
#(
  parameter  int unsigned COL_NUM  = CONF_PE_COL,
  parameter  int unsigned FM_DEPTH = CONF_FM_BUF_DEPTH,
  parameter  int unsigned GD_DEPTH = CONF_GUARD_BUF_DEPTH,
  localparam int unsigned FM_AW    = $clog2(FM_DEPTH),
  localparam int unsigned GD_AW    = $clog2(GD_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [FM_AW:0]                  fm_words_i,
  input  logic [GD_AW:0]                  gd_words_i,
  input  logic                            bit_mode_i,
  input  logic                            is_diff_i,
  input  logic [71:0]                     s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [COL_NUM-1:0][FM_AW-1:0]   load_fm_wr_addr,
  output logic [COL_NUM-1:0][71:0]        load_fm_din,
  output logic [COL_NUM-1:0]              load_fm_wr_en,
  output logic [COL_NUM-1:0][GD_AW-1:0]   load_gd_wr_addr,
  output logic [COL_NUM-1:0][71:0]        load_gd_din,
  output logic [COL_NUM-1:0]              load_gd_wr_en,
  output logic                            core_valid,
  input  logic                            core_ready,
  input  logic                            core_finish,
  output logic                            core_bit_mode_o,
  output logic                            core_is_diff_o,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CW     = clog2_min1(COL_NUM);
  localparam int unsigned CNT_AW = (FM_AW > GD_AW) ? FM_AW : GD_AW;

  load_state_e       state;
  logic [FM_AW:0]    fm_words_q;
  logic [GD_AW:0]    gd_words_q;

  logic              fm_empty;
  logic              gd_empty;
  logic              accept;
  logic              fm_end;
  logic              gd_end;
  logic              cnt_clr;
  logic              cnt_last;
  logic [CW-1:0]     cnt_col;
  logic [CNT_AW-1:0] cnt_addr;
  logic [CNT_AW:0]   cnt_words;

  assign fm_empty = (fm_words_q == '0);
  assign gd_empty = (gd_words_q == '0);

  // An empty phase still occupies its state for one cycle, but never
  // advertises readiness, so no stream word can be consumed by it.
  assign s_ready  = ((state == LOAD_FM) && !fm_empty) ||
                    ((state == LOAD_GD) && !gd_empty);
  assign accept   = s_valid && s_ready;

  assign cnt_words = (state == LOAD_GD) ? (CNT_AW+1)'(gd_words_q)
                                        : (CNT_AW+1)'(fm_words_q);

  assign fm_end  = (state == LOAD_FM) && (fm_empty || (accept && cnt_last));
  assign gd_end  = (state == LOAD_GD) && (gd_empty || (accept && cnt_last));
  // One counter serves both phases: it restarts on job accept and again
  // on the fm -> guard hand-over.
  assign cnt_clr = ((state == IDLE) && start) || fm_end;

  assign core_valid = (state == REQ);
  assign busy       = (state != IDLE);

  load_addr_cnt #(
    .COLS (COL_NUM),
    .AW   (CNT_AW)
  ) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (accept),
    .words (cnt_words),
    .col   (cnt_col),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      fm_words_q      <= '0;
      gd_words_q      <= '0;
      core_bit_mode_o <= 1'b0;
      core_is_diff_o  <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            fm_words_q      <= (fm_words_i > (FM_AW+1)'(FM_DEPTH)) ?
                               (FM_AW+1)'(FM_DEPTH) : fm_words_i;
            gd_words_q      <= (gd_words_i > (GD_AW+1)'(GD_DEPTH)) ?
                               (GD_AW+1)'(GD_DEPTH) : gd_words_i;
            core_bit_mode_o <= bit_mode_i;
            core_is_diff_o  <= is_diff_i;
            state           <= LOAD_FM;
          end
        end
        LOAD_FM: begin
          if (fm_end) state <= LOAD_GD;
        end
        LOAD_GD: begin
          if (gd_end) state <= REQ;
        end
        REQ: begin
          if (core_ready) state <= RUN;
        end
        RUN: begin
          if (core_finish) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write ports: the accepted word lands on its column one cycle later;
  // idle columns present zero address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_fm_wr_en   <= '0;
      load_fm_wr_addr <= '0;
      load_fm_din     <= '0;
      load_gd_wr_en   <= '0;
      load_gd_wr_addr <= '0;
      load_gd_din     <= '0;
    end else begin
      for (int unsigned c = 0; c < COL_NUM; c++) begin
        if (accept && (state == LOAD_FM) && (cnt_col == CW'(c))) begin
          load_fm_wr_en[c]   <= 1'b1;
          load_fm_wr_addr[c] <= FM_AW'(cnt_addr);
          load_fm_din[c]     <= s_data;
        end else begin
          load_fm_wr_en[c]   <= 1'b0;
          load_fm_wr_addr[c] <= '0;
          load_fm_din[c]     <= '0;
        end
        if (accept && (state == LOAD_GD) && (cnt_col == CW'(c))) begin
          load_gd_wr_en[c]   <= 1'b1;
          load_gd_wr_addr[c] <= GD_AW'(cnt_addr);
          load_gd_din[c]     <= s_data;
        end else begin
          load_gd_wr_en[c]   <= 1'b0;
          load_gd_wr_addr[c] <= '0;
          load_gd_din[c]     <= '0;
        end
      end
    end
  end

endmodule
